// File: rtl/gfx_timing_pkg.sv
// gfx_timing_pkg
//   Shared constants for the video timing generator. The defaults reproduce
//   the GBA LCD frame: 240x160 visible inside a 308x228 dot raster, 4 system
//   clocks per dot. cnt_w() sizes a counter that must hold 0..n-1. It returns
//   at least 1 so that a one-state counter, such as the dot divider at
//   DOTDIV=1, still has a legal width.
package gfx_timing_pkg;

    localparam int GBA_H_ACTIVE = 240;
    localparam int GBA_H_TOTAL  = 308;
    localparam int GBA_V_ACTIVE = 160;
    localparam int GBA_V_TOTAL  = 228;
    localparam int GBA_DOTDIV   = 4;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gfx_wrap_counter.sv
// gfx_wrap_counter
//   Modulo counter that counts 0..MAX and then wraps to 0.
//   Ports:
//     clock  - clock
//     reset  - synchronous, active-high; forces q to 0
//     en     - advance one step
//     clear  - force q to 0 on the next edge; takes priority over en
//     q      - current count
//     last   - q == MAX; the next enabled step wraps
module gfx_wrap_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    output logic [WIDTH-1:0] q,
    output logic             last
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] q_d, q_q;

    assign last = (q_q == MAX_V);
    assign q    = q_q;

    always_comb begin
        q_d = q_q;
        if (clear)
            q_d = '0;
        else if (en)
            q_d = last ? '0 : q_q + WIDTH'(1);
    end

    always_ff @(posedge clock) begin
        if (reset)
            q_q <= '0;
        else
            q_q <= q_d;
    end

endmodule

// File: rtl/gfx_timing_gen.sv
// gfx_timing_gen
//   Parametrised raster timing generator and front/back buffer controller.
//   Ports:
//     clock, reset   - clock and synchronous active-high reset
//     enable         - advance timing; when low, all state is frozen
//     vcount_cmp     - line number compared against vcount
//     frame_ready    - renderer has finished the back buffer
//     hcount/vcount  - current dot and current line
//     dot_strobe     - one-cycle pulse at each dot boundary
//     pixel_valid    - frame-buffer write enable (inside the active area)
//     pixel_addr     - linear frame-buffer write address
//     hblank/vblank  - blanking levels
//     hblank_pulse, vblank_pulse, vcount_pulse - one-clock entry pulses
//     vcount_hit     - level, vcount == vcount_cmp
//     buf_select     - front buffer index
//     frame_dropped  - one-clock pulse, the swap at vblank entry was skipped
module gfx_timing_gen
    import gfx_timing_pkg::*;
#(
    parameter  int H_ACTIVE = GBA_H_ACTIVE,
    parameter  int H_TOTAL  = GBA_H_TOTAL,
    parameter  int V_ACTIVE = GBA_V_ACTIVE,
    parameter  int V_TOTAL  = GBA_V_TOTAL,
    parameter  int DOTDIV   = GBA_DOTDIV,
    localparam int HCNT_W   = $clog2(H_TOTAL),
    localparam int VCNT_W   = $clog2(V_TOTAL),
    localparam int ADDR_W   = $clog2(H_ACTIVE * V_ACTIVE)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [VCNT_W-1:0] vcount_cmp,
    input  logic              frame_ready,
    output logic [HCNT_W-1:0] hcount,
    output logic [VCNT_W-1:0] vcount,
    output logic              dot_strobe,
    output logic              pixel_valid,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              hblank,
    output logic              vblank,
    output logic              hblank_pulse,
    output logic              vblank_pulse,
    output logic              vcount_pulse,
    output logic              vcount_hit,
    output logic              buf_select,
    output logic              frame_dropped
);

    localparam int DIV_W = cnt_w(DOTDIV);

    if (H_ACTIVE >= H_TOTAL) begin : g_bad_h
        $error("gfx_timing_gen: H_ACTIVE must be less than H_TOTAL");
    end
    if (V_ACTIVE >= V_TOTAL) begin : g_bad_v
        $error("gfx_timing_gen: V_ACTIVE must be less than V_TOTAL");
    end
    if (DOTDIV < 1) begin : g_bad_div
        $error("gfx_timing_gen: DOTDIV must be at least 1");
    end

    logic [DIV_W-1:0]  div_cnt;
    logic              div_last, h_last, v_last, addr_last;
    logic              line_wrap, frame_wrap, pix_step;
    logic [VCNT_W-1:0] vcount_next;

    assign dot_strobe = enable && div_last;
    assign line_wrap  = dot_strobe && h_last;
    assign frame_wrap = line_wrap && v_last;
    assign pix_step   = dot_strobe && pixel_valid;

    gfx_wrap_counter #(.WIDTH(DIV_W), .MAX(DOTDIV - 1)) u_div (
        .clock(clock), .reset(reset), .en(enable), .clear(1'b0),
        .q(div_cnt), .last(div_last)
    );

    gfx_wrap_counter #(.WIDTH(HCNT_W), .MAX(H_TOTAL - 1)) u_hcnt (
        .clock(clock), .reset(reset), .en(dot_strobe), .clear(1'b0),
        .q(hcount), .last(h_last)
    );

    gfx_wrap_counter #(.WIDTH(VCNT_W), .MAX(V_TOTAL - 1)) u_vcnt (
        .clock(clock), .reset(reset), .en(line_wrap), .clear(1'b0),
        .q(vcount), .last(v_last)
    );

    // Wrapping at the last visible pixel leaves the address at 0 through
    // vblank. The frame-wrap clear re-aligns it should it ever drift.
    gfx_wrap_counter #(.WIDTH(ADDR_W), .MAX(H_ACTIVE * V_ACTIVE - 1)) u_addr (
        .clock(clock), .reset(reset), .en(pix_step), .clear(frame_wrap),
        .q(pixel_addr), .last(addr_last)
    );

    logic unused_sigs;
    assign unused_sigs = ^{div_cnt, addr_last};

    assign pixel_valid = (hcount < HCNT_W'(H_ACTIVE)) && (vcount < VCNT_W'(V_ACTIVE));
    assign hblank      = (hcount >= HCNT_W'(H_ACTIVE));
    assign vblank      = (vcount >= VCNT_W'(V_ACTIVE));
    assign vcount_hit  = (vcount == vcount_cmp);
    assign vcount_next = v_last ? '0 : vcount + VCNT_W'(1);

    logic hbp_d, hbp_q, vbp_d, vbp_q, vcp_d, vcp_q, fd_d, fd_q, buf_d, buf_q;
    logic hb_ev, vb_ev, vc_ev;

    // Events are detected on the strobe that moves the counters, so the
    // registered pulse lines up with the new hcount/vcount. The swap and the
    // drop flag are updated on the same edge as the vblank pulse.
    // While enable is low, the pulse flops hold their value and the outputs
    // are masked. This way a pulse pending when enable drops is delivered
    // when timing resumes.
    always_comb begin
        hb_ev = dot_strobe && (hcount == HCNT_W'(H_ACTIVE - 1));
        vb_ev = line_wrap && (vcount_next == VCNT_W'(V_ACTIVE));
        vc_ev = line_wrap && (vcount_next == vcount_cmp);
        hbp_d = hbp_q;
        vbp_d = vbp_q;
        vcp_d = vcp_q;
        fd_d  = fd_q;
        buf_d = buf_q;
        if (enable) begin
            hbp_d = hb_ev;
            vbp_d = vb_ev;
            vcp_d = vc_ev;
            fd_d  = vb_ev && !frame_ready;
            buf_d = buf_q ^ (vb_ev && frame_ready);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hbp_q <= 1'b0;
            vbp_q <= 1'b0;
            vcp_q <= 1'b0;
            fd_q  <= 1'b0;
            buf_q <= 1'b0;
        end else begin
            hbp_q <= hbp_d;
            vbp_q <= vbp_d;
            vcp_q <= vcp_d;
            fd_q  <= fd_d;
            buf_q <= buf_d;
        end
    end

    assign hblank_pulse  = hbp_q && enable;
    assign vblank_pulse  = vbp_q && enable;
    assign vcount_pulse  = vcp_q && enable;
    assign frame_dropped = fd_q && enable;
    assign buf_select    = buf_q;

endmodule

// File: tb/tb_gfx_timing_gen.sv
module tb_gfx_timing_gen;

    // Instance A: mid-size raster, random stimulus against a reference model.
    localparam int AHA = 24, AHT = 31, AVA = 16, AVT = 23, AD = 4;
    localparam int AFR = AD * AHT * AVT;
    // Instance B: tiny raster, vector table plus hand-written sequences.
    localparam int BHA = 4, BHT = 6, BVA = 3, BVT = 5, BD = 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic       a_rst, a_en, a_fr;
    logic [4:0] a_cmp, a_h, a_v;
    logic [8:0] a_addr;
    logic       a_ds, a_pv, a_hb, a_vb, a_hbp, a_vbp, a_vcp, a_hit, a_buf, a_fd;

    logic       b_rst, b_en, b_fr;
    logic [2:0] b_cmp, b_h, b_v;
    logic [3:0] b_addr;
    logic       b_ds, b_pv, b_hb, b_vb, b_hbp, b_vbp, b_vcp, b_hit, b_buf, b_fd;

    gfx_timing_gen #(.H_ACTIVE(AHA), .H_TOTAL(AHT), .V_ACTIVE(AVA), .V_TOTAL(AVT), .DOTDIV(AD)) dut_a (
        .clock(clock), .reset(a_rst), .enable(a_en), .vcount_cmp(a_cmp), .frame_ready(a_fr),
        .hcount(a_h), .vcount(a_v), .dot_strobe(a_ds), .pixel_valid(a_pv), .pixel_addr(a_addr),
        .hblank(a_hb), .vblank(a_vb), .hblank_pulse(a_hbp), .vblank_pulse(a_vbp),
        .vcount_pulse(a_vcp), .vcount_hit(a_hit), .buf_select(a_buf), .frame_dropped(a_fd)
    );

    gfx_timing_gen #(.H_ACTIVE(BHA), .H_TOTAL(BHT), .V_ACTIVE(BVA), .V_TOTAL(BVT), .DOTDIV(BD)) dut_b (
        .clock(clock), .reset(b_rst), .enable(b_en), .vcount_cmp(b_cmp), .frame_ready(b_fr),
        .hcount(b_h), .vcount(b_v), .dot_strobe(b_ds), .pixel_valid(b_pv), .pixel_addr(b_addr),
        .hblank(b_hb), .vblank(b_vb), .hblank_pulse(b_hbp), .vblank_pulse(b_vbp),
        .vcount_pulse(b_vcp), .vcount_hit(b_hit), .buf_select(b_buf), .frame_dropped(b_fd)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected B state after a number of enabled cycles from reset.
    typedef struct {
        int n;
        int h;
        int v;
        bit pv;
        int addr;
        bit hb;
        bit vb;
    } vec_t;
    vec_t tbl[8];

    // Reference model for A. It is kept as a count of enabled clocks since
    // reset. Raster position, address and blanking are derived from this
    // count with plain arithmetic.
    int t;
    bit m_buf, p_hb, p_vb, p_vc, p_fd;

    function automatic int m_h(input int tt);
        return (tt / AD) % AHT;
    endfunction
    function automatic int m_v(input int tt);
        return ((tt / AD) / AHT) % AVT;
    endfunction
    function automatic int m_addr(input int tt);
        int h, v, a;
        h = m_h(tt);
        v = m_v(tt);
        if (v >= AVA)
            return 0;
        a = v * AHA + ((h < AHA) ? h : AHA);
        return (a == AHA * AVA) ? 0 : a;
    endfunction

    int npv, nhb, nvb, nfd;

    initial begin
        tbl[0] = '{0,  0, 0, 1, 0,  0, 0};
        tbl[1] = '{3,  3, 0, 1, 3,  0, 0};
        tbl[2] = '{1,  4, 0, 0, 4,  1, 0};
        tbl[3] = '{2,  0, 1, 1, 4,  0, 0};
        tbl[4] = '{9,  3, 2, 1, 11, 0, 0};
        tbl[5] = '{1,  4, 2, 0, 0,  1, 0};
        tbl[6] = '{2,  0, 3, 0, 0,  0, 1};
        tbl[7] = '{12, 0, 0, 1, 0,  0, 0};

        a_rst = 1; a_en = 0; a_fr = 0; a_cmp = 0;
        b_rst = 1; b_en = 0; b_fr = 1; b_cmp = 0;
        repeat (2) @(negedge clock);

        // ---------------- Instance B: table ----------------
        b_rst = 0; b_en = 1;
        #1;
        check("b_reset_state", {b_h, b_v, b_pv, b_addr, b_hb, b_vb, b_hit, b_buf, b_hbp, b_vbp, b_fd},
              {3'd0, 3'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 8; i++) begin
            repeat (tbl[i].n) @(negedge clock);
            #1;
            check($sformatf("b_vec%0d_h", i), b_h, tbl[i].h);
            check($sformatf("b_vec%0d_v", i), b_v, tbl[i].v);
            check($sformatf("b_vec%0d_pv", i), b_pv, tbl[i].pv);
            check($sformatf("b_vec%0d_addr", i), b_addr, tbl[i].addr);
            check($sformatf("b_vec%0d_blank", i), {b_hb, b_vb}, {tbl[i].hb, tbl[i].vb});
        end

        // One full frame from dot 30: valid count, hblank pulses, single swap.
        npv = 0; nhb = 0; nvb = 0;
        for (int i = 0; i < 30; i++) begin
            if (b_pv) npv++;
            if (b_hbp) nhb++;
            if (b_vbp) nvb++;
            @(negedge clock);
            #1;
        end
        check("b_frame_pv_count", npv, 12);
        check("b_frame_hbp_count", nhb, 5);
        check("b_frame_vbp_count", nvb, 1);
        check("b_buf_after_2_swaps", b_buf, 0);

        // Renderer not ready: swap skipped, one drop pulse.
        b_fr = 0; nfd = 0;
        for (int i = 0; i < 30; i++) begin
            if (b_fd) nfd++;
            @(negedge clock);
            #1;
        end
        check("b_drop_count", nfd, 1);
        check("b_buf_held", b_buf, 0);

        // Ready again: next frame swaps.
        b_fr = 1; nfd = 0;
        for (int i = 0; i < 30; i++) begin
            if (b_fd) nfd++;
            @(negedge clock);
            #1;
        end
        check("b_no_drop", nfd, 0);
        check("b_buf_toggled", b_buf, 1);

        // Mid-frame reset with buf_select=1.
        repeat (10) @(negedge clock);
        b_rst = 1;
        @(negedge clock);
        #1;
        check("b_midframe_reset", {b_h, b_v, b_pv, b_addr, b_hb, b_vb, b_hit, b_buf, b_hbp, b_vbp, b_vcp, b_fd},
              {3'd0, 3'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

        // Enable low for 50 cycles while B sits mid-line after reset release.
        b_rst = 0;
        repeat (2) @(negedge clock);
        b_en = 0;
        nhb = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            #1;
            if (b_hbp || b_vbp || b_ds) nhb++;
        end
        check("b_frozen_pos", {b_h, b_v, b_addr, b_buf}, {3'd2, 3'd0, 4'd2, 1'b0});
        check("b_frozen_no_pulse", nhb, 0);
        b_en = 1;
        @(negedge clock);
        #1;
        check("b_resume_pos", {b_h, b_addr}, {3'd3, 4'd3});

        // ---------------- Instance A: random vs model ----------------
        t = 0; m_buf = 0; p_hb = 0; p_vb = 0; p_vc = 0; p_fd = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            bit strobe, linechg;
            int nt, h, v, nh, nv;
            @(negedge clock);
            a_rst = (cyc < 2) || (cyc == 6000) || ($urandom_range(0, 2999) == 0);
            a_en  = (cyc >= 1000 && cyc < 1050) ? 1'b0 : ($urandom_range(0, 19) != 0);
            a_fr  = 1'($urandom_range(0, 1));
            if (cyc % 700 == 0) a_cmp = 5'($urandom_range(0, AVT - 1));
            #1;
            h = m_h(t);
            v = m_v(t);
            strobe = ((t % AD) == AD - 1);
            check($sformatf("a_cyc%0d", cyc),
                  {a_h, a_v, a_ds, a_pv, a_addr, a_hb, a_vb, a_hbp, a_vbp, a_vcp, a_hit, a_buf, a_fd},
                  {5'(h), 5'(v), a_en && strobe, (h < AHA) && (v < AVA), 9'(m_addr(t)),
                   h >= AHA, v >= AVA, p_hb && a_en, p_vb && a_en, p_vc && a_en,
                   v == int'(a_cmp), m_buf, p_fd && a_en});
            if (a_rst) begin
                t = 0; m_buf = 0; p_hb = 0; p_vb = 0; p_vc = 0; p_fd = 0;
            end else if (a_en) begin
                nt = (t + 1) % AFR;
                nh = m_h(nt);
                nv = m_v(nt);
                linechg = strobe && (nv != v);
                p_hb = strobe && (nh == AHA);
                p_vb = linechg && (nv == AVA);
                p_vc = linechg && (nv == int'(a_cmp));
                p_fd = p_vb && !a_fr;
                if (p_vb && a_fr) m_buf = !m_buf;
                t = nt;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
